scan_sel_seq: RTL and testbench
===============================

// Module: scan_sel_seq
// PURPOSE
//  Upstream sequencer for the 2-to-4 enable decoder; drives its E, A, B inputs.
//  Steps a 2-bit slot index {B,A} through the enabled slots of a 4-bit mask.
//  Holds each slot for DWELL cycles, with an optional BLANK gap (E=0) between slots.
//  Typical use: 4-digit display or row multiplexing, in continuous or single-pass mode.
// PARAMETERS
//  DWELL  4  cycles E=1 per slot (>=1)
//  BLANK  1  cycles E=0 between slots (>=0; 0 = no gap)
//  CNT_W  8  width of internal dwell/blank counter (must hold max(DWELL,BLANK))
// PORTS
//  clk    in   1  single clock, rising edge
//  rst    in   1  synchronous reset, active-high
//  start  in   1  begin a scan (sampled only in IDLE)
//  stop   in   1  abort scan (any state)
//  mode   in   1  0 = continuous wrap, 1 = single pass; latched at start
//  mask   in   4  slot enables, bit i = slot i; latched at start
//  E      out  1  decoder enable (registered)
//  A      out  1  slot index LSB (registered)
//  B      out  1  slot index MSB (registered)
//  busy   out  1  high in ACTIVE/BLANK
//  done   out  1  1-cycle pulse on single-pass completion
// BEHAVIOUR
//  - All outputs are registered. Reset (rst=1 at an edge): state=IDLE, E=A=B=0,
//    busy=0, done=0, counter=0, latched mask/mode=0. Reset overrides all inputs.
//  - States: IDLE, ACTIVE, GAP.
//  - IDLE: start=1, stop=0 and mask!=0 -> latch mask/mode; slot=lowest set bit;
//    ACTIVE. E=1, {B,A}=slot, busy=1 are visible the cycle after start.
//    start with mask==0 is ignored. stop wins over start in the same cycle.
//  - ACTIVE: E=1 for exactly DWELL cycles. At the end of the slot:
//    * mode=1 and no set bit above slot -> IDLE; E=0, busy=0, done=1 for 1 cycle.
//    * otherwise, BLANK>0 -> GAP: E=0, A/B held, for exactly BLANK cycles.
//    * otherwise, BLANK=0 -> next slot directly; E stays 1 and A/B change.
//  - GAP: at end -> ACTIVE with the next slot.
//  - Next slot = next set bit above the current one, wrapping 3->0 (continuous mode).
//    A single-bit mask in continuous mode repeats the same slot.
//  - Continuous period = n*(DWELL+BLANK) cycles, where n = popcount(mask).
//  - stop=1 in ACTIVE/GAP -> IDLE next cycle: E=0, busy=0, A/B hold last slot, no done.
//  - start while busy: ignored. mask/mode changes while busy: ignored until next start.
//  - E is never 1 in IDLE. done is never asserted together with busy.
// TESTING
//  1. rst high 2 cycles -> E=A=B=busy=done=0; release, no start -> outputs stay 0.
//  2. DWELL=4, BLANK=1, mask=4'b1111, mode=1, start pulse -> {B,A}=0,1,2,3, each E=1
//     for 4 cycles, E=0 for 1 cycle between slots; done pulses once after slot 3;
//     busy=0 from that cycle; no GAP after slot 3.
//  3. mask=4'b1010, mode=0 -> slots 1,3,1,3... with period 10 cycles; then stop ->
//     E=0, busy=0 next cycle, done stays 0.
//  4. BLANK=0, mask=4'b0101, mode=0 -> E continuously 1; {B,A} toggles 0/2 every 4 cycles.
//  5. start with mask=0 -> stays IDLE; start+stop same cycle -> stays IDLE;
//     start while busy -> sequence unchanged.
//  6. rst asserted mid-ACTIVE -> all outputs 0 next cycle; later start restarts at the
//     lowest set bit.

Source files
------------

// File: rtl/scan_sel_seq.sv
// ---------------------------------------------------------------------------
// scan_sel_seq
//   Upstream sequencer for a 2-to-4 enable decoder. It steps a 2-bit slot
//   index {B,A} through the enabled bits of a 4-bit mask. Each slot is held
//   with E=1 for DWELL cycles. An optional gap of BLANK cycles with E=0
//   separates consecutive slots. It runs in continuous (wrapping) or
//   single-pass mode.
//
// Parameters
//   DWELL  cycles with E=1 per slot (>=1)
//   BLANK  cycles with E=0 between slots (>=0, 0 = no gap)
//   CNT_W  width of the dwell/blank counter, must hold max(DWELL, BLANK)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   begin a scan (sampled only while idle)
//   stop   in   abort a scan (any state)
//   mode   in   0 = continuous wrap, 1 = single pass (latched at start)
//   mask   in   slot enables, bit i = slot i (latched at start)
//   E      out  decoder enable (registered)
//   A      out  slot index LSB (registered)
//   B      out  slot index MSB (registered)
//   busy   out  high while a scan is in progress
//   done   out  1-cycle pulse when a single pass completes
// ---------------------------------------------------------------------------
module scan_sel_seq #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [3:0] mask,
  output logic       E,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  // Clamped so that BLANK=0 does not produce a negative constant. GAP is
  // never entered in that configuration.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam bit               HAS_GAP    = (BLANK > 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       slot_q,  slot_d;
  logic [3:0]       mask_q,  mask_d;
  logic             mode_q,  mode_d;
  logic             e_q,     e_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             has_above;

  // Lowest set bit of the mask. The scan entry point.
  function automatic logic [1:0] lowest_slot(input logic [3:0] m);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) s = 2'(i);
    end
    return s;
  endfunction

  // Next set bit after cur, wrapping 3->0. If no other bit is set, the
  // function returns cur, so a single-bit mask repeats its slot.
  function automatic logic [1:0] next_slot(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] s;
    logic [1:0] idx;
    s = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) s = idx;
    end
    return s;
  endfunction

  // Any enabled slot strictly above the current one. Single-pass mode uses
  // it to detect the final slot.
  assign has_above = |(mask_q >> ({1'b0, slot_q} + 3'd1));

  always_comb begin
    // NOTE: every next-state signal gets a default hold value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop && (mask != 4'd0)) begin
          state_d = ST_ACTIVE;
          mask_d  = mask;
          mode_d  = mode;
          slot_d  = lowest_slot(mask);
          cnt_d   = '0;
          e_d     = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (stop) begin
          state_d = ST_IDLE;
          e_d     = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (mode_q && !has_above) begin
            // The final slot of a single pass skips the trailing gap.
            state_d = ST_IDLE;
            e_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (HAS_GAP) begin
            state_d = ST_GAP;
            e_d     = 1'b0;
          end else begin
            slot_d = next_slot(mask_q, slot_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          slot_d  = next_slot(mask_q, slot_q);
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        e_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments only. The blocking
  // form would let later flops see this edge's new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      slot_q  <= 2'd0;
      mask_q  <= 4'd0;
      mode_q  <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign E    = e_q;
  assign A    = slot_q[0];
  assign B    = slot_q[1];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_scan_sel_seq.sv
// ---------------------------------------------------------------------------
// tb_scan_sel_seq
//   Drives three scan_sel_seq instances in parallel from shared inputs:
//     inst 0: DWELL=4, BLANK=1
//     inst 1: DWELL=4, BLANK=0
//     inst 2: DWELL=1, BLANK=2
//   For each scan, the expected output of every cycle is written out as a
//   trace from the mask, mode, DWELL and BLANK. The bench then compares the
//   DUT outputs cycle by cycle against that trace.
// ---------------------------------------------------------------------------
module tb_scan_sel_seq;

  localparam int NI = 3;

  typedef struct packed {
    logic       e;
    logic [1:0] slot;
    logic       busy;
    logic       done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst, start, stop, mode;
  logic [3:0]    mask;
  logic [NI-1:0] e_o, a_o, b_o, busy_o, done_o;

  int   vectors    = 0;
  int   miscompares = 0;
  obs_t exp_q [NI][$];
  logic [1:0] held [NI];

  always #5 clk = ~clk;

  scan_sel_seq #(.DWELL(4), .BLANK(1), .CNT_W(8)) u_d4_b1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .E(e_o[0]), .A(a_o[0]), .B(b_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  scan_sel_seq #(.DWELL(4), .BLANK(0), .CNT_W(8)) u_d4_b0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .E(e_o[1]), .A(a_o[1]), .B(b_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  scan_sel_seq #(.DWELL(1), .BLANK(2), .CNT_W(8)) u_d1_b2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .E(e_o[2]), .A(a_o[2]), .B(b_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  function automatic int dw_of(input int k);
    case (k)
      0:       return 4;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int bl_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic obs_t mk(input logic e, input logic [1:0] s, input logic bz, input logic dn);
    obs_t o;
    o.e = e; o.slot = s; o.busy = bz; o.done = dn;
    return o;
  endfunction

  function automatic obs_t observed(input int k);
    return mk(e_o[k], {b_o[k], a_o[k]}, busy_o[k], done_o[k]);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle output after a start. The first entry is the cycle
  // right after the start edge.
  task automatic build_trace(input int k, input logic [3:0] m, input logic md, input int ncyc);
    int slots[$];
    int j;
    exp_q[k].delete();
    for (int i = 0; i < 4; i++) if (m[i]) slots.push_back(i);
    if (md) begin
      for (int n = 0; n < slots.size(); n++) begin
        repeat (dw_of(k)) exp_q[k].push_back(mk(1'b1, 2'(slots[n]), 1'b1, 1'b0));
        if (n != slots.size() - 1)
          repeat (bl_of(k)) exp_q[k].push_back(mk(1'b0, 2'(slots[n]), 1'b1, 1'b0));
      end
      exp_q[k].push_back(mk(1'b0, 2'(slots[slots.size()-1]), 1'b0, 1'b1));
    end else begin
      j = 0;
      while (exp_q[k].size() < ncyc) begin
        repeat (dw_of(k)) exp_q[k].push_back(mk(1'b1, 2'(slots[j]), 1'b1, 1'b0));
        repeat (bl_of(k)) exp_q[k].push_back(mk(1'b0, 2'(slots[j]), 1'b1, 1'b0));
        j = (j + 1) % slots.size();
      end
      while (exp_q[k].size() > ncyc) void'(exp_q[k].pop_back());
    end
  endtask

  // One scan from idle. Continuous scans run ncyc cycles and then get
  // stopped. In continuous mode, inject adds ignored start pulses and
  // changes mask/mode while the scan is busy.
  task automatic run_scan(input logic [3:0] m, input logic md, input int ncyc,
                          input bit inject, input string tag);
    int   len;
    obs_t got, want;
    len = 0;
    for (int k = 0; k < NI; k++) begin
      build_trace(k, m, md, ncyc);
      if (exp_q[k].size() > len) len = exp_q[k].size();
    end
    if (md) begin
      len += 2;
      for (int k = 0; k < NI; k++)
        while (exp_q[k].size() < len)
          exp_q[k].push_back(mk(1'b0, exp_q[k][exp_q[k].size()-1].slot, 1'b0, 1'b0));
    end

    start = 1'b1; mask = m; mode = md;
    step();
    start = 1'b0; mask = 4'($urandom); mode = 1'($urandom);

    for (int c = 0; c < len; c++) begin
      for (int k = 0; k < NI; k++) begin
        got  = observed(k);
        want = exp_q[k][c];
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL %s inst=%0d cycle=%0d {E,BA,busy,done} got=%b expected=%b",
                   tag, k, c, got, want);
        end
      end
      if (c != len - 1) begin
        if (!md && inject && ($urandom_range(0, 3) == 0)) begin
          start = 1'b1; mask = 4'($urandom); mode = 1'($urandom);
        end else begin
          start = 1'b0;
        end
        step();
      end
    end
    start = 1'b0;

    if (!md) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      for (int k = 0; k < NI; k++) begin
        got  = observed(k);
        want = mk(1'b0, exp_q[k][len-1].slot, 1'b0, 1'b0);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL %s_stop inst=%0d {E,BA,busy,done} got=%b expected=%b",
                   tag, k, got, want);
        end
      end
    end
    for (int k = 0; k < NI; k++) held[k] = exp_q[k][len-1].slot;
  endtask

  task automatic test_reset;
    obs_t got;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 4'd0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 1) rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
        got = observed(k);
        vectors++;
        if (got !== mk(1'b0, 2'd0, 1'b0, 1'b0)) begin
          miscompares++;
          $display("FAIL reset inst=%0d cycle=%0d got=%b expected=00000", k, c, got);
        end
      end
    end
    for (int k = 0; k < NI; k++) held[k] = 2'd0;
  endtask

  task automatic test_single_pass;
    logic [3:0] m;
    run_scan(4'b1111, 1'b1, 0, 1'b0, "single_1111");
    run_scan(4'b1000, 1'b1, 0, 1'b0, "single_1000");
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(1, 15));
      run_scan(m, 1'b1, 0, 1'b0, "single_rand");
    end
  endtask

  task automatic test_continuous;
    logic [3:0] m;
    run_scan(4'b1010, 1'b0, 30, 1'b0, "cont_1010");
    run_scan(4'b0101, 1'b0, 24, 1'b0, "cont_0101");
    run_scan(4'b0100, 1'b0, 12, 1'b0, "cont_single_bit");
    for (int r = 0; r < 5; r++) begin
      m = 4'($urandom_range(1, 15));
      run_scan(m, 1'b0, $urandom_range(5, 40), 1'b1, "cont_rand_busy_start");
    end
  endtask

  task automatic test_ignored_start;
    obs_t got;
    // Zero mask, then start and stop in the same cycle: neither may leave idle.
    for (int p = 0; p < 2; p++) begin
      start = 1'b1;
      stop  = (p == 1);
      mask  = (p == 0) ? 4'd0 : 4'b0110;
      mode  = 1'($urandom);
      step();
      start = 1'b0; stop = 1'b0;
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < NI; k++) begin
          got = observed(k);
          vectors++;
          if (got !== mk(1'b0, held[k], 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL ignored_start case=%0d inst=%0d got=%b expected=%b",
                     p, k, got, mk(1'b0, held[k], 1'b0, 1'b0));
          end
        end
        if (c != 2) step();
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_t       got;
    logic [3:0] m;
    m = 4'($urandom_range(2, 15));
    start = 1'b1; mask = m; mode = 1'b0;
    step();
    start = 1'b0;
    repeat ($urandom_range(1, 6)) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      got = observed(k);
      vectors++;
      if (got !== mk(1'b0, 2'd0, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL reset_mid inst=%0d got=%b expected=00000", k, got);
      end
      held[k] = 2'd0;
    end
    run_scan(m, 1'b1, 0, 1'b0, "restart_after_reset");
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_continuous();
    test_ignored_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
